// File: rtl/rr_bus_arbiter_if.sv
// Shared-bus bundle between the cores, the round-robin arbiter and the single DRAM/MMIO path.
// The master modport is the surrounding system (cores plus memory); the slave modport is the arbiter.
interface rr_bus_arbiter_if #(
    parameter int NCORES = 2,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int CW     = 3
);
    logic [NCORES-1:0]    core_switch_ok;
    logic [NCORES*AW-1:0] core_addr;
    logic [NCORES*DW-1:0] core_wdata;
    logic [NCORES-1:0]    core_we;
    logic [NCORES-1:0]    core_le;
    logic [NCORES*CW-1:0] core_ctrl;
    logic [NCORES*DW-1:0] core_rdata;
    logic [NCORES-1:0]    core_busy;

    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic                 mem_we;
    logic                 mem_le;
    logic [CW-1:0]        mem_ctrl;
    logic [DW-1:0]        mem_rdata;
    logic                 mem_busy;

    modport master (
        output core_switch_ok, core_addr, core_wdata, core_we, core_le, core_ctrl,
        input  core_rdata, core_busy,
        input  mem_addr, mem_wdata, mem_we, mem_le, mem_ctrl,
        output mem_rdata, mem_busy
    );

    modport slave (
        input  core_switch_ok, core_addr, core_wdata, core_we, core_le, core_ctrl,
        output core_rdata, core_busy,
        output mem_addr, mem_wdata, mem_we, mem_le, mem_ctrl,
        input  mem_rdata, mem_busy
    );
endinterface

// File: rtl/rr_bus_arbiter.sv
// Round-robin time-multiplexer of one memory bus across NCORES cores; RR_ARB_STATS_EN adds handoff counters.
// Latency: combinational request/response mux; a handoff costs DRAIN + SWITCH + (quantum+1) QUANT cycles.
// Backpressure: granted core sees mem_busy in RUN/QUANT and a stall while switching; others always stall.
module rr_bus_arbiter #(
    parameter int NCORES = 2,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int CW     = 3,
    parameter int GW     = $clog2(NCORES)
) (
    input  logic                 CLK,
    input  logic                 RST_X,
    input  logic                 init_done,
    input  logic [NCORES-1:0]    core_en,
    input  logic [7:0]           quantum,
    rr_bus_arbiter_if.slave      bus,
    output logic [GW-1:0]        grant,
    output logic [NCORES-1:0]    grant_onehot,
    output logic                 switching,
    output logic [NCORES*16-1:0] stats_cnt
);
    typedef enum logic [1:0] {RUN, DRAIN, SWITCH, QUANT} state_t;

    state_t        state;
    logic [7:0]    cnt;
    logic [GW-1:0] next_grant;
    logic          grant_live;

    logic [AW-1:0] addr_a  [NCORES];
    logic [DW-1:0] wdata_a [NCORES];
    logic [CW-1:0] ctrl_a  [NCORES];

    assign grant_live = (state == RUN) || (state == QUANT);
    assign switching  = (state == DRAIN) || (state == SWITCH);

    // Walk offsets from farthest to nearest so the nearest enabled core wins.
    always_comb begin
        next_grant = grant;
        for (int k = NCORES - 1; k >= 1; k--) begin
            int idx;
            idx = int'(grant) + k;
            if (idx >= NCORES) idx = idx - NCORES;
            if (core_en[idx]) next_grant = GW'(idx);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            state <= RUN;
            grant <= '0;
            cnt   <= '0;
        end else if (init_done) begin
            unique case (state)
                RUN: begin
                    if (bus.core_switch_ok[grant] && !bus.mem_busy) state <= DRAIN;
                end
                DRAIN: begin
                    grant <= next_grant;
                    state <= SWITCH;
                end
                SWITCH: begin
                    cnt   <= '0;
                    state <= QUANT;
                end
                QUANT: begin
                    if (cnt < quantum) cnt <= cnt + 8'd1;
                    else               state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    for (genvar i = 0; i < NCORES; i++) begin : g_core
        assign addr_a[i]  = bus.core_addr[i*AW +: AW];
        assign wdata_a[i] = bus.core_wdata[i*DW +: DW];
        assign ctrl_a[i]  = bus.core_ctrl[i*CW +: CW];

        assign grant_onehot[i]            = (grant == GW'(i));
        assign bus.core_rdata[i*DW +: DW] = grant_onehot[i] ? bus.mem_rdata : '0;
        assign bus.core_busy[i]           = grant_onehot[i] ? (bus.mem_busy || !grant_live) : 1'b1;

`ifdef RR_ARB_STATS_EN
        logic [15:0] stat_q;
        always_ff @(posedge CLK) begin
            if (!RST_X) begin
                stat_q <= '0;
            end else if (init_done && state == SWITCH && grant_onehot[i] && stat_q != 16'hFFFF) begin
                stat_q <= stat_q + 16'd1;
            end
        end
        assign stats_cnt[i*16 +: 16] = stat_q;
`endif
    end

`ifndef RR_ARB_STATS_EN
    assign stats_cnt = '0;
`endif

    assign bus.mem_addr  = addr_a[grant];
    assign bus.mem_wdata = wdata_a[grant];
    assign bus.mem_ctrl  = ctrl_a[grant];
    assign bus.mem_we    = bus.core_we[grant];
    assign bus.mem_le    = bus.core_le[grant];
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter with four cores: handoff table, datapath table and corner sequences.
module tb_rr_bus_arbiter;
    localparam int N = 4;

    logic          CLK;
    logic          RST_X;
    logic          init_done;
    logic [N-1:0]  core_en;
    logic [7:0]    quantum;
    logic [1:0]    grant;
    logic [N-1:0]  grant_onehot;
    logic          switching;
    logic [N*16-1:0] stats_cnt;

    int checks = 0;
    int errors = 0;

    rr_bus_arbiter_if #(.NCORES(N), .AW(32), .DW(32), .CW(3)) bus ();

    rr_bus_arbiter #(.NCORES(N), .AW(32), .DW(32), .CW(3), .GW(2)) dut (
        .CLK          (CLK),
        .RST_X        (RST_X),
        .init_done    (init_done),
        .core_en      (core_en),
        .quantum      (quantum),
        .bus          (bus.slave),
        .grant        (grant),
        .grant_onehot (grant_onehot),
        .switching    (switching),
        .stats_cnt    (stats_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] en;
        logic [7:0] q;
        logic [1:0] g;
    } ho_vec_t;

    typedef struct {
        logic [127:0] addr_all;
        logic [127:0] wdata_all;
        logic [3:0]   we;
        logic [3:0]   le;
        logic [11:0]  ctrl_all;
        logic [31:0]  rdata;
        logic         busy;
        logic [31:0]  exp_addr;
        logic [31:0]  exp_wdata;
        logic         exp_we;
        logic         exp_le;
        logic [2:0]   exp_ctrl;
        logic [127:0] exp_rdata;
        logic [3:0]   exp_busy;
    } dp_vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    ho_vec_t     hv [13];
    dp_vec_t     dv [3];
    int          stat_model [N];
    logic [3:0]  exp_oh;
    logic [3:0]  exp_busy;
    logic [63:0] exp_stats;

    initial begin
        hv[0]  = '{4'b1111, 8'd1,   2'd1};
        hv[1]  = '{4'b1011, 8'd0,   2'd3};
        hv[2]  = '{4'b1011, 8'd2,   2'd0};
        hv[3]  = '{4'b1011, 8'd1,   2'd1};
        hv[4]  = '{4'b0011, 8'd1,   2'd0};
        hv[5]  = '{4'b0011, 8'd1,   2'd1};
        hv[6]  = '{4'b0011, 8'd1,   2'd0};
        hv[7]  = '{4'b0001, 8'd0,   2'd0};
        hv[8]  = '{4'b0000, 8'd0,   2'd0};
        hv[9]  = '{4'b0100, 8'd3,   2'd2};
        hv[10] = '{4'b1111, 8'd0,   2'd3};
        hv[11] = '{4'b1111, 8'd1,   2'd0};
        hv[12] = '{4'b1111, 8'd255, 2'd1};

        dv[0] = '{{32'h4000_0003, 32'h3000_0002, 32'h2000_0001, 32'h1000_0000},
                  {32'h0000_00D3, 32'h0000_00D2, 32'h0000_00D1, 32'h0000_00D0},
                  4'b0100, 4'b1011, {3'd7, 3'd5, 3'd1, 3'd0}, 32'hDEAD_BEEF, 1'b0,
                  32'h3000_0002, 32'h0000_00D2, 1'b1, 1'b0, 3'd5,
                  {32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0}, 4'b1011};
        dv[1] = '{{32'hAAAA_0003, 32'hBBBB_0002, 32'hCCCC_0001, 32'hDDDD_0000},
                  {32'h1111_1113, 32'h2222_2222, 32'h3333_3331, 32'h4444_4440},
                  4'b1011, 4'b0100, {3'd2, 3'd6, 3'd3, 3'd4}, 32'h1234_5678, 1'b1,
                  32'hBBBB_0002, 32'h2222_2222, 1'b0, 1'b1, 3'd6,
                  {32'h0, 32'h1234_5678, 32'h0, 32'h0}, 4'b1111};
        dv[2] = '{{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                  {32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
                  4'b1011, 4'b1011, {3'd7, 3'd0, 3'd7, 3'd7}, 32'hFFFF_FFFF, 1'b0,
                  32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 3'd0,
                  {32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0}, 4'b1011};

        for (int i = 0; i < N; i++) stat_model[i] = 0;

        RST_X              = 1'b0;
        init_done          = 1'b1;
        core_en            = 4'b1111;
        quantum            = 8'd1;
        bus.core_switch_ok = '0;
        bus.core_addr      = '0;
        bus.core_wdata     = '0;
        bus.core_we        = '0;
        bus.core_le        = '0;
        bus.core_ctrl      = '0;
        bus.mem_rdata      = '0;
        bus.mem_busy       = 1'b0;
        tick;
        tick;

        chk("rst_grant", grant, 2'd0);
        chk("rst_onehot", grant_onehot, 4'b0001);
        chk("rst_switching", switching, 1'b0);
        chk("rst_busy_idle", bus.core_busy, 4'b1110);
        chk("rst_rdata", bus.core_rdata, 128'h0);
        chk("rst_stats", stats_cnt, 64'h0);
        bus.mem_busy = 1'b1;
        #1;
        chk("rst_busy_membusy", bus.core_busy, 4'b1111);
        bus.mem_busy = 1'b0;

        RST_X = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("no_ok_switching", switching, 1'b0);
            chk("no_ok_grant", grant, 2'd0);
        end

        bus.mem_busy       = 1'b1;
        bus.core_switch_ok = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            tick;
            chk("busy_hold_switching", switching, 1'b0);
            chk("busy_hold_grant", grant, 2'd0);
            chk("busy_hold_core_busy", bus.core_busy, 4'b1111);
        end
        bus.mem_busy = 1'b0;
        tick;
        chk("busy_release_drain", switching, 1'b1);

        // Each vector is applied during a DRAIN cycle and governs that handoff plus the following QUANT.
        for (int v = 0; v < 13; v++) begin
            core_en = hv[v].en;
            quantum = hv[v].q;
            tick;
            exp_oh = 4'b0001 << hv[v].g;
            chk("ho_grant", grant, hv[v].g);
            chk("ho_onehot", grant_onehot, exp_oh);
            chk("ho_switch_phase", switching, 1'b1);
            chk("ho_switch_busy", bus.core_busy, 4'b1111);
            stat_model[hv[v].g]++;
            for (int n = 1; n <= int'(hv[v].q) + 3; n++) begin
                tick;
                exp_busy = (n == int'(hv[v].q) + 3) ? 4'b1111 : ~exp_oh;
                chk("ho_dwell_switching", switching, (n == int'(hv[v].q) + 3));
                chk("ho_dwell_busy", bus.core_busy, exp_busy);
            end
        end

`ifdef RR_ARB_STATS_EN
        for (int i = 0; i < N; i++) exp_stats[i*16 +: 16] = 16'(stat_model[i]);
`else
        exp_stats = '0;
`endif
        chk("stats_after_table", stats_cnt, exp_stats);

        core_en = 4'b1111;
        quantum = 8'd0;
        tick;
        chk("pre_reset_switch_grant", grant, 2'd2);
        chk("pre_reset_switching", switching, 1'b1);
        RST_X = 1'b0;
        tick;
        chk("mid_switch_reset_grant", grant, 2'd0);
        chk("mid_switch_reset_run", switching, 1'b0);
        chk("mid_switch_reset_stats", stats_cnt, 64'h0);
        RST_X              = 1'b1;
        bus.core_switch_ok = '0;
        tick;
        chk("post_reset_run", switching, 1'b0);
        chk("post_reset_grant", grant, 2'd0);

        core_en            = 4'b0100;
        bus.core_switch_ok = 4'b0001;
        tick;
        chk("to_core2_drain", switching, 1'b1);
        bus.core_switch_ok = '0;
        tick;
        chk("to_core2_grant", grant, 2'd2);
        tick;
        tick;
        chk("core2_run", switching, 1'b0);

        for (int v = 0; v < 3; v++) begin
            bus.core_addr  = dv[v].addr_all;
            bus.core_wdata = dv[v].wdata_all;
            bus.core_we    = dv[v].we;
            bus.core_le    = dv[v].le;
            bus.core_ctrl  = dv[v].ctrl_all;
            bus.mem_rdata  = dv[v].rdata;
            bus.mem_busy   = dv[v].busy;
            #1;
            chk("dp_mem_addr", bus.mem_addr, dv[v].exp_addr);
            chk("dp_mem_wdata", bus.mem_wdata, dv[v].exp_wdata);
            chk("dp_mem_we", bus.mem_we, dv[v].exp_we);
            chk("dp_mem_le", bus.mem_le, dv[v].exp_le);
            chk("dp_mem_ctrl", bus.mem_ctrl, dv[v].exp_ctrl);
            chk("dp_core_rdata", bus.core_rdata, dv[v].exp_rdata);
            chk("dp_core_busy", bus.core_busy, dv[v].exp_busy);
        end

        bus.mem_busy       = 1'b0;
        init_done          = 1'b0;
        core_en            = 4'b1111;
        bus.core_switch_ok = 4'b1111;
        for (int c = 0; c < 50; c++) begin
            tick;
            chk("frozen_grant", grant, 2'd2);
            chk("frozen_switching", switching, 1'b0);
        end
        bus.mem_rdata = 32'hCAFE_0001;
        #1;
        chk("frozen_datapath_live", bus.core_rdata, {32'h0, 32'hCAFE_0001, 32'h0, 32'h0});

        init_done = 1'b1;
        tick;
        chk("thaw_drain", switching, 1'b1);
        quantum = 8'd200;
        tick;
        chk("thaw_grant", grant, 2'd3);
        tick;
        tick;
        tick;
        chk("long_quant_running", switching, 1'b0);
        quantum = 8'd2;
        tick;
        chk("quant_shrunk_run", switching, 1'b0);
        tick;
        chk("quant_shrunk_drain", switching, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
